// File: rtl/button_event_queue_if.sv
// Handshake bundle between the debouncer/consumer side and the button event queue.
// The queue uses the slave modport, and the environment that drives it uses the master modport.
interface button_event_queue_if #(
    parameter int ADDR_W = 3
);
    logic              buttons_valid_unused;
    logic [4:0]        buttons_in;
    logic              clear_in;
    logic              event_ready_in;
    logic              event_valid_out;
    logic [2:0]        event_code_out;
    logic [ADDR_W:0]   count_out;
    logic              overflow_out;

    modport master (
        output buttons_in,
        output clear_in,
        output event_ready_in,
        input  event_valid_out,
        input  event_code_out,
        input  count_out,
        input  overflow_out
    );

    modport slave (
        input  buttons_in,
        input  clear_in,
        input  event_ready_in,
        output event_valid_out,
        output event_code_out,
        output count_out,
        output overflow_out
    );
endinterface

// File: rtl/button_event_queue.sv
// Encodes debounced button pulses into 3-bit codes and buffers them in a FWFT FIFO.
// Consumers drain the codes with a valid/ready handshake.
module button_event_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    button_event_queue_if.slave   bus
);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

    logic [2:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [2:0]        pushCode;
    logic              push;
    logic              pop;
    logic              isFull;
    logic              isEmpty;
    logic              pushAccept;

    // Lowest set bit wins, so simultaneous presses collapse to a single entry.
    always_comb begin
        pushCode = 3'd0;
        if      (bus.buttons_in[0]) pushCode = 3'd1;
        else if (bus.buttons_in[1]) pushCode = 3'd2;
        else if (bus.buttons_in[2]) pushCode = 3'd3;
        else if (bus.buttons_in[3]) pushCode = 3'd4;
        else if (bus.buttons_in[4]) pushCode = 3'd5;
    end

    assign push    = |bus.buttons_in;
    assign isFull  = (count_q == FULL_COUNT);
    assign isEmpty = (count_q == '0);
    assign pop     = bus.event_ready_in & ~isEmpty;

    // A full queue still takes a press when the head leaves in the same cycle.
    assign pushAccept = push & (~isFull | pop) & ~bus.clear_in;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.clear_in) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pushAccept) wrPtr_d = wrPtr_q + PTR_ONE;
            if (pop)        rdPtr_d = rdPtr_q + PTR_ONE;
            if (pushAccept && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !pushAccept) count_d = count_q - CNT_ONE;
            if (push && isFull && !pop)  overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset because count gates every read of it.
    always_ff @(posedge clock_in) begin
        if (pushAccept) mem_q[wrPtr_q] <= pushCode;
    end

    assign bus.event_valid_out = ~isEmpty;
    assign bus.event_code_out  = isEmpty ? 3'd0 : mem_q[rdPtr_q];
    assign bus.count_out       = count_q;
    assign bus.overflow_out    = overflow_q;
endmodule
